// File: rtl/aap_dbg_reg_port_pkg.sv
// Shared constants and types for the debug register-port initiator:
// command opcodes, response codes, processor-state encoding and FSM states.
package aap_dbg_reg_port_pkg;

  localparam int          STATE_W      = 3;
  localparam logic [2:0]  STATE_HALTED = 3'd2;

  localparam logic [7:0]  DBG_OP_READ  = 8'h01;
  localparam logic [7:0]  DBG_OP_WRITE = 8'h02;
  localparam logic [7:0]  DBG_ACK      = 8'h06;
  localparam logic [7:0]  DBG_NAK      = 8'h15;

  typedef enum logic [2:0] {
    DBGP_IDLE    = 3'd0,
    DBGP_GET_REG = 3'd1,
    DBGP_GET_LO  = 3'd2,
    DBGP_GET_HI  = 3'd3,
    DBGP_EXEC    = 3'd4,
    DBGP_RESP0   = 3'd5,
    DBGP_RESP1   = 3'd6
  } dbgp_state_e;

  // True for the two opcodes that start a register command.
  function automatic logic is_rw_op(input logic [7:0] op);
    return (op == DBG_OP_READ) || (op == DBG_OP_WRITE);
  endfunction

endpackage

// File: rtl/aap_dbg_reg_port_if.sv
// Bundle of the command stream, response stream, processor state and the
// register file's debug port. master = the debug initiator, slave = its
// environment (transport, response consumer, register file).
interface aap_dbg_reg_port_if;
  import aap_dbg_reg_port_pkg::*;

  logic [STATE_W-1:0] state;
  logic [7:0]         cmd_data;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         rsp_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [5:0]         dbg_reg_rregnum;
  logic [15:0]        dbg_reg_rdata;
  logic [5:0]         dbg_reg_wregnum;
  logic [15:0]        dbg_reg_wdata;
  logic               dbg_reg_we;

  modport master (
    input  state, cmd_data, cmd_valid, rsp_ready, dbg_reg_rdata,
    output cmd_ready, rsp_data, rsp_valid,
           dbg_reg_rregnum, dbg_reg_wregnum, dbg_reg_wdata, dbg_reg_we
  );

  modport slave (
    output state, cmd_data, cmd_valid, rsp_ready, dbg_reg_rdata,
    input  cmd_ready, rsp_data, rsp_valid,
           dbg_reg_rregnum, dbg_reg_wregnum, dbg_reg_wdata, dbg_reg_we
  );

endinterface

// File: rtl/aap_dbg_reg_port.sv
// Debug register-port initiator: parses READ/WRITE byte commands, drives the
// register file's debug port while the core is halted, and returns data,
// ACK or NAK bytes. One command in flight at a time.
module aap_dbg_reg_port
  import aap_dbg_reg_port_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic               clk,
  input  logic               rst,
  aap_dbg_reg_port_if.master bus
);

  localparam logic [8:0] LP_NUM_REGS = 9'(NUM_REGS);

  dbgp_state_e r_state;
  dbgp_state_e w_next;

  logic        r_is_wr;
  logic        r_bad_op;
  logic        r_bad_reg;
  logic        r_rd_ok;
  logic [5:0]  r_regnum;
  logic [15:0] r_wdata;
  logic [15:0] r_rsp;

  logic        w_err;
  logic        w_cmd_ready;
  logic        w_rsp_valid;
  logic [7:0]  w_rsp_data;
  logic        w_we;

  // Halted is judged only at EXEC; a core leaving HALTED mid-command gets a NAK.
  assign w_err = r_bad_op | r_bad_reg | (bus.state != STATE_HALTED);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DBGP_IDLE;
    else     r_state <= w_next;
  end

  // Next state, stream handshakes and the one-cycle write strobe
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 8'h00;
    w_we        = 1'b0;
    case (r_state)
      DBGP_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = is_rw_op(bus.cmd_data) ? DBGP_GET_REG : DBGP_EXEC;
      end
      DBGP_GET_REG: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = r_is_wr ? DBGP_GET_LO : DBGP_EXEC;
      end
      DBGP_GET_LO: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = DBGP_GET_HI;
      end
      DBGP_GET_HI: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = DBGP_EXEC;
      end
      DBGP_EXEC: begin
        w_we   = r_is_wr & ~w_err;
        w_next = DBGP_RESP0;
      end
      DBGP_RESP0: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = r_rsp[7:0];
        if (bus.rsp_ready) w_next = r_rd_ok ? DBGP_RESP1 : DBGP_IDLE;
      end
      DBGP_RESP1: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = r_rsp[15:8];
        if (bus.rsp_ready) w_next = DBGP_IDLE;
      end
      default: w_next = DBGP_IDLE;
    endcase
  end

  // Capture command fields as bytes arrive; form the response in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr   <= 1'b0;
      r_bad_op  <= 1'b0;
      r_bad_reg <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_regnum  <= 6'd0;
      r_wdata   <= 16'h0000;
      r_rsp     <= 16'h0000;
    end else begin
      case (r_state)
        DBGP_IDLE: if (bus.cmd_valid) begin
          r_is_wr   <= (bus.cmd_data == DBG_OP_WRITE);
          r_bad_op  <= ~is_rw_op(bus.cmd_data);
          r_bad_reg <= 1'b0;
        end
        DBGP_GET_REG: if (bus.cmd_valid) begin
          // Range check uses the full byte so e.g. 0x45 cannot alias reg 5.
          r_regnum  <= bus.cmd_data[5:0];
          r_bad_reg <= ({1'b0, bus.cmd_data} >= LP_NUM_REGS);
        end
        DBGP_GET_LO: if (bus.cmd_valid) r_wdata[7:0]  <= bus.cmd_data;
        DBGP_GET_HI: if (bus.cmd_valid) r_wdata[15:8] <= bus.cmd_data;
        DBGP_EXEC: begin
          r_rd_ok <= ~r_is_wr & ~w_err;
          if (w_err)        r_rsp <= {8'h00, DBG_NAK};
          else if (r_is_wr) r_rsp <= {8'h00, DBG_ACK};
          else              r_rsp <= bus.dbg_reg_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready       = w_cmd_ready;
  assign bus.rsp_valid       = w_rsp_valid;
  assign bus.rsp_data        = w_rsp_data;
  assign bus.dbg_reg_we      = w_we;
  assign bus.dbg_reg_rregnum = r_regnum;
  assign bus.dbg_reg_wregnum = r_regnum;
  assign bus.dbg_reg_wdata   = r_wdata;

endmodule

// File: tb/tb_aap_dbg_reg_port.sv
// Bench for aap_dbg_reg_port: a register-file model answers the debug port,
// a reference model predicts response bytes and writes into queues, and a
// negedge monitor pops and compares whatever the DUT presents.
module tb_aap_dbg_reg_port;
  import aap_dbg_reg_port_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aap_dbg_reg_port_if bus();

  aap_dbg_reg_port #(.NUM_REGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_hs = 0;
  int rsp_mode = 0;   // 0: ready high, 1: random, 2: held low

  logic [7:0]  exp_q[$];
  logic [21:0] wr_q[$];
  logic [15:0] model_rf[16];

  // Register file seen by the DUT (write effect only while halted)
  logic [15:0] rf[16];
  logic        rf_init;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'hA5A0 ^ 16'(i * 37);
    end else if (bus.dbg_reg_we && bus.state == STATE_HALTED && bus.dbg_reg_wregnum < 6'd16) begin
      rf[bus.dbg_reg_wregnum[3:0]] <= bus.dbg_reg_wdata;
    end
  end

  assign bus.dbg_reg_rdata = (bus.dbg_reg_rregnum < 6'd16) ? rf[bus.dbg_reg_rregnum[3:0]] : 16'hDEAD;

  // Response consumer and scoreboard monitor
  logic [7:0]  mon_e;
  logic [21:0] mon_w;
  always @(negedge clk) begin
    case (rsp_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = 1'($urandom_range(0, 1));
      default: bus.rsp_ready = 1'b0;
    endcase
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got %02h, required no byte", bus.rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rsp_data !== mon_e) begin
          fails++;
          $display("FAIL rsp_byte: got %02h, required %02h (cyc %0d)", bus.rsp_data, mon_e, cyc);
        end
      end
    end
    if (!rst && bus.dbg_reg_we) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL we_unexpected: got reg %0d data %04h, required no write",
                 bus.dbg_reg_wregnum, bus.dbg_reg_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if ({bus.dbg_reg_wregnum, bus.dbg_reg_wdata} !== mon_w || cyc != last_hs + 1) begin
          fails++;
          $display("FAIL we_write: got reg %0d data %04h cyc %0d, required reg %0d data %04h cyc %0d",
                   bus.dbg_reg_wregnum, bus.dbg_reg_wdata, cyc, mon_w[21:16], mon_w[15:0], last_hs + 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data",  32'(bus.rsp_data), 0);
    chk("rst_we",        32'(bus.dbg_reg_we), 0);
    chk("rst_rregnum",   32'(bus.dbg_reg_rregnum), 0);
    chk("rst_wregnum",   32'(bus.dbg_reg_wregnum), 0);
    chk("rst_wdata",     32'(bus.dbg_reg_wdata), 0);
  endtask

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL cmd_ready_timeout: got 0, required 1");
    end else begin
      last_hs = cyc;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    bus.cmd_valid = 1'b0;
    while (!(exp_q.size() == 0 && bus.cmd_ready && !bus.rsp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d bytes pending, required 0", exp_q.size());
    end
  endtask

  // Reference model: predict the response and any write, then send the bytes.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] rn, input logic [15:0] d,
                        input bit halted, output int first);
    bit bad;
    bad = (rn >= 8'd16) || !halted;
    if (op != DBG_OP_READ && op != DBG_OP_WRITE) begin
      exp_q.push_back(DBG_NAK);
    end else if (op == DBG_OP_READ) begin
      if (bad) exp_q.push_back(DBG_NAK);
      else begin
        exp_q.push_back(model_rf[rn[3:0]][7:0]);
        exp_q.push_back(model_rf[rn[3:0]][15:8]);
      end
    end else begin
      if (bad) exp_q.push_back(DBG_NAK);
      else begin
        exp_q.push_back(DBG_ACK);
        wr_q.push_back({rn[5:0], d});
        model_rf[rn[3:0]] = d;
      end
    end
    send_byte(op);
    first = last_hs;
    if (op == DBG_OP_READ || op == DBG_OP_WRITE) begin
      send_byte(rn);
      if (op == DBG_OP_WRITE) begin
        send_byte(d[7:0]);
        send_byte(d[15:8]);
      end
    end
  endtask

  logic [2:0] NOT_HALTED;
  int f[6];
  int dummy;
  int t;
  logic [15:0] sv_val;

  initial begin
    NOT_HALTED     = STATE_HALTED ^ 3'd5;
    rst            = 1'b1;
    rf_init        = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = 8'h00;
    bus.state      = STATE_HALTED;
    for (int i = 0; i < 16; i++) model_rf[i] = 16'hA5A0 ^ 16'(i * 37);

    repeat (3) @(negedge clk);
    check_reset_vals();
    rst     = 1'b0;
    rf_init = 1'b0;
    @(negedge clk);

    // Directed: write then read back, halted
    do_cmd(DBG_OP_WRITE, 8'd5, 16'h1234, 1'b1, dummy);
    wait_drain();
    do_cmd(DBG_OP_READ, 8'd5, 16'h0, 1'b1, dummy);
    wait_drain();

    // Not halted: write refused, old value survives
    bus.state = NOT_HALTED;
    do_cmd(DBG_OP_WRITE, 8'd3, 16'hBEEF, 1'b0, dummy);
    wait_drain();
    bus.state = STATE_HALTED;
    do_cmd(DBG_OP_READ, 8'd3, 16'h0, 1'b1, dummy);
    wait_drain();

    // Out-of-range registers, including one that aliases in 6 bits
    do_cmd(DBG_OP_READ,  8'd16,  16'h0,    1'b1, dummy);
    do_cmd(DBG_OP_WRITE, 8'd16,  16'h5555, 1'b1, dummy);
    do_cmd(DBG_OP_WRITE, 8'h45,  16'h6666, 1'b1, dummy);
    wait_drain();

    // Leaving HALTED mid-command: still collected, then NAKed
    exp_q.push_back(DBG_NAK);
    send_byte(DBG_OP_WRITE);
    send_byte(8'd4);
    bus.state = NOT_HALTED;
    send_byte(8'h11);
    send_byte(8'h22);
    wait_drain();
    bus.state = STATE_HALTED;

    // Response back-pressure holds data_lo and blocks commands
    rsp_mode = 2;
    sv_val   = model_rf[2];
    do_cmd(DBG_OP_READ, 8'd2, 16'h0, 1'b1, dummy);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_data",  32'(bus.rsp_data), 32'(sv_val[7:0]));
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
      @(negedge clk);
    end
    rsp_mode = 0;
    wait_drain();

    // Reset after data_lo of a write: dropped, no strobe, outputs cleared
    do_cmd(DBG_OP_WRITE, 8'd7, 16'hC0DE, 1'b1, dummy);
    wait_drain();
    send_byte(DBG_OP_WRITE);
    send_byte(8'd9);
    send_byte(8'h77);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(DBG_OP_READ, 8'd9, 16'h0, 1'b1, dummy);
    wait_drain();

    // Back-to-back with ready tied high: command periods 5 / 6 / 3
    do_cmd(DBG_OP_READ,  8'd2, 16'h0,    1'b1, f[0]);
    do_cmd(DBG_OP_WRITE, 8'd2, 16'h0F0F, 1'b1, f[1]);
    do_cmd(DBG_OP_READ,  8'd2, 16'h0,    1'b1, f[2]);
    do_cmd(DBG_OP_WRITE, 8'd4, 16'h4321, 1'b1, f[3]);
    do_cmd(8'h7F,        8'd0, 16'h0,    1'b1, f[4]);
    do_cmd(DBG_OP_READ,  8'd4, 16'h0,    1'b1, f[5]);
    wait_drain();
    chk("b2b_read_period",   32'(f[1] - f[0]), 5);
    chk("b2b_write_period",  32'(f[2] - f[1]), 6);
    chk("b2b_read_period2",  32'(f[3] - f[2]), 5);
    chk("b2b_write_period2", 32'(f[4] - f[3]), 6);
    chk("b2b_badop_period",  32'(f[5] - f[4]), 3);

    // Randomized commands, random back-pressure and processor state
    rsp_mode = 1;
    for (int n = 0; n < 60; n++) begin
      logic [7:0]  op;
      logic [7:0]  rn;
      logic [15:0] d;
      int          r;
      bit          h;
      h = ($urandom_range(0, 3) != 0);
      bus.state = h ? STATE_HALTED : (STATE_HALTED ^ 3'($urandom_range(1, 7)));
      r = $urandom_range(0, 9);
      if (r < 5)      op = DBG_OP_READ;
      else if (r < 9) op = DBG_OP_WRITE;
      else            op = 8'($urandom_range(3, 255));
      rn = ($urandom_range(0, 9) == 0) ? 8'h45 : 8'($urandom_range(0, 19));
      d  = 16'($urandom);
      do_cmd(op, rn, d, h, dummy);
      if ($urandom_range(0, 1) == 0) wait_drain();
      else begin
        // keep the state stable until this command has executed
        bus.cmd_valid = 1'b0;
        t = 0;
        while (!bus.rsp_valid && t < 50) begin @(negedge clk); t++; end
      end
    end
    rsp_mode = 0;
    wait_drain();

    chk("final_rsp_queue_empty", 32'(exp_q.size()), 0);
    chk("final_wr_queue_empty",  32'(wr_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
